bpu_btb_predictor: RTL and testbench

//  Next-generation fetch PC generator for the frontend: holds the fetch PC and emits per-slot valid masks for an aligned FETCH_WIDTH fetch block.

---
 rtl/bpu_btb_predictor.sv | 121 ++++++++++++
 tb/tb_bpu_btb_predictor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_btb_predictor.sv
// rtl/bpu_btb_predictor.sv - fetch PC generator with direct-mapped BTB and 2-bit direction counters
module bpu_btb_predictor #(
  parameter int          FETCH_WIDTH = 4,
  parameter int          BTB_DEPTH   = 64,
  parameter int          TAG_W       = 10,
  parameter logic [31:0] RESET_PC    = 32'h1c00_0000
) (
  input  logic                           clk,
  input  logic                           a_rst,
  input  logic                           next_i,
  input  logic                           redirect_i,
  input  logic [31:0]                    redirect_pc_i,
  input  logic                           upd_valid_i,
  input  logic [31:0]                    upd_pc_i,
  input  logic [31:0]                    upd_target_i,
  input  logic                           upd_taken_i,
  output logic [31:0]                    pc_o,
  output logic [31:0]                    npc_o,
  output logic [FETCH_WIDTH-1:0]         valid_o,
  output logic                           pred_taken_o,
  output logic [$clog2(FETCH_WIDTH)-1:0] pred_slot_o
);
  localparam int SW    = $clog2(FETCH_WIDTH);
  localparam int OFS   = SW + 2;
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int PW    = 32 - OFS;

  logic [31:0]      pc_q, npc_d;
  logic             btb_v_q   [BTB_DEPTH];
  logic [TAG_W-1:0] btb_tag_q [BTB_DEPTH];
  logic [31:0]      btb_tgt_q [BTB_DEPTH];
  logic [1:0]       cnt_q     [BTB_DEPTH];

  logic [SW-1:0]    start_slot, hit_slot;
  logic             hit_any;
  logic [31:0]      hit_tgt, slot_addr;
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             u_hit, fetch_ok;

  assign start_slot = pc_q[OFS-1:2];

  // Scan from the top slot down so the last assignment is the lowest hitting slot
  always_comb begin
    hit_any   = 1'b0;
    hit_slot  = '0;
    hit_tgt   = '0;
    slot_addr = '0;
    l_idx     = '0;
    l_tag     = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      slot_addr = {pc_q[31:OFS], SW'(i), 2'b00};
      l_idx     = slot_addr[IDX_W+1:2];
      l_tag     = slot_addr[TAG_W+IDX_W+1:IDX_W+2];
      if (SW'(i) >= start_slot && btb_v_q[l_idx] && btb_tag_q[l_idx] == l_tag && cnt_q[l_idx][1]) begin
        hit_any  = 1'b1;
        hit_slot = SW'(i);
        hit_tgt  = btb_tgt_q[l_idx];
      end
    end
  end

  assign fetch_ok = next_i && !redirect_i && !a_rst;

  always_comb begin
    valid_o = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      valid_o[i] = fetch_ok && (SW'(i) >= start_slot) && (!hit_any || SW'(i) <= hit_slot);
    end
  end

  always_comb begin
    if (redirect_i)   npc_d = {redirect_pc_i[31:2], 2'b00};
    else if (!next_i) npc_d = pc_q;
    else if (hit_any) npc_d = hit_tgt;
    else              npc_d = {pc_q[31:OFS] + PW'(1), {OFS{1'b0}}};
  end

  assign pc_o         = pc_q;
  assign npc_o        = a_rst ? RESET_PC : npc_d;
  assign pred_taken_o = hit_any;
  assign pred_slot_o  = hit_slot;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) pc_q <= RESET_PC;
    else       pc_q <= npc_d;
  end

  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = upd_pc_i[TAG_W+IDX_W+1:IDX_W+2];
  assign u_hit = btb_v_q[u_idx] && btb_tag_q[u_idx] == u_tag;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int k = 0; k < BTB_DEPTH; k++) btb_v_q[k] <= 1'b0;
    end else if (upd_valid_i && upd_taken_i) begin
      btb_v_q[u_idx] <= 1'b1;
    end
  end

  // Tag/target payload needs no reset: it is only observed behind a valid bit
  always_ff @(posedge clk) begin
    if (upd_valid_i && upd_taken_i) begin
      btb_tag_q[u_idx] <= u_tag;
      btb_tgt_q[u_idx] <= upd_target_i;
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int k = 0; k < BTB_DEPTH; k++) cnt_q[k] <= 2'b01;
    end else if (upd_valid_i) begin
      if (upd_taken_i && u_hit)       cnt_q[u_idx] <= (cnt_q[u_idx] == 2'b11) ? 2'b11 : cnt_q[u_idx] + 2'b01;
      else if (upd_taken_i)           cnt_q[u_idx] <= 2'b10;
      else if (u_hit)                 cnt_q[u_idx] <= (cnt_q[u_idx] == 2'b00) ? 2'b00 : cnt_q[u_idx] - 2'b01;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{redirect_pc_i[1:0], upd_pc_i[31:TAG_W+IDX_W+2], upd_pc_i[1:0], slot_addr};
endmodule

// File: tb/tb_bpu_btb_predictor.sv
// tb/tb_bpu_btb_predictor.sv - directed and randomized checks against a table-level reference model
module tb_bpu_btb_predictor;
  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        a_rst = 1'b1;
  logic        next_i = 1'b0, redirect_i = 1'b0, upd_valid_i = 1'b0, upd_taken_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, upd_pc_i = '0, upd_target_i = '0;
  logic [31:0] pc_o, npc_o;
  logic [3:0]  valid_o;
  logic        pred_taken_o;
  logic [1:0]  pred_slot_o;

  int tests = 0;
  int fails = 0;

  bpu_btb_predictor dut (
    .clk(clk), .a_rst(a_rst), .next_i(next_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_target_i(upd_target_i), .upd_taken_i(upd_taken_i), .pc_o(pc_o), .npc_o(npc_o),
    .valid_o(valid_o), .pred_taken_o(pred_taken_o), .pred_slot_o(pred_slot_o)
  );

  always #5 clk = ~clk;

  // Reference model: one record per BTB index, counter kept as an integer 0..3
  logic [31:0] m_pc;
  bit          m_v   [64];
  int          m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_cnt [64];

  task automatic model_reset();
    m_pc = RST_PC;
    for (int k = 0; k < 64; k++) begin
      m_v[k] = 0; m_cnt[k] = 1; m_tag[k] = 0; m_tgt[k] = '0;
    end
  endtask

  task automatic model_update(input logic [31:0] upc, input logic [31:0] utgt, input bit utk);
    int idx, tg;
    bit hit;
    idx = int'((upc >> 2) % 64);
    tg  = int'((upc >> 8) % 1024);
    hit = m_v[idx] && m_tag[idx] == tg;
    if (utk) begin
      m_cnt[idx] = hit ? ((m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3) : 2;
      m_v[idx] = 1; m_tag[idx] = tg; m_tgt[idx] = utgt;
    end else if (hit) begin
      m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
    end
  endtask

  task automatic predict(input logic [31:0] pc, output bit tk, output int slot, output logic [31:0] tgt);
    logic [31:0] base, a;
    int s, idx, tg;
    tk = 0; slot = 0; tgt = '0;
    base = pc & ~32'hF;
    s = int'((pc >> 2) % 4);
    for (int i = s; i < 4; i++) begin
      a   = base + 32'(4 * i);
      idx = int'((a >> 2) % 64);
      tg  = int'((a >> 8) % 1024);
      if (!tk && m_v[idx] && m_tag[idx] == tg && m_cnt[idx] >= 2) begin
        tk = 1; slot = i; tgt = m_tgt[idx];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit nx, input bit rd, input logic [31:0] rpc,
                       input bit uv, input logic [31:0] upc, input logic [31:0] utgt, input bit utk);
    next_i = nx; redirect_i = rd; redirect_pc_i = rpc;
    upd_valid_i = uv; upd_pc_i = upc; upd_target_i = utgt; upd_taken_i = utk;
  endtask

  // Check the current block against the model, then clock it and advance the model
  task automatic cycle();
    bit          tk;
    int          sl;
    logic [31:0] tg, enpc;
    logic [3:0]  ev;
    @(negedge clk);
    predict(m_pc, tk, sl, tg);
    ev = '0;
    for (int i = 0; i < 4; i++)
      ev[i] = next_i && !redirect_i && (i >= int'((m_pc >> 2) % 4)) && (!tk || i <= sl);
    if (redirect_i)   enpc = redirect_pc_i & ~32'h3;
    else if (!next_i) enpc = m_pc;
    else if (tk)      enpc = tg;
    else              enpc = (m_pc & ~32'hF) + 32'h10;
    chk("pc", pc_o, m_pc);
    chk("npc", npc_o, enpc);
    chk("valid", 32'(valid_o), 32'(ev));
    chk("pred_taken", 32'(pred_taken_o), 32'(tk));
    chk("pred_slot", 32'(pred_slot_o), 32'(sl));
    @(posedge clk);
    m_pc = enpc;
    if (upd_valid_i) model_update(upd_pc_i, upd_target_i, upd_taken_i);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_npc", npc_o, RST_PC);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_pred", 32'(pred_taken_o), 32'h0);
    chk("rst_slot", 32'(pred_slot_o), 32'h0);
    @(negedge clk);
    a_rst = 1'b0;
    @(posedge clk); #1;

    // sequential fetch, empty BTB
    drive(1, 0, '0, 0, '0, '0, 0);
    repeat (2) cycle();
    chk("seq_pc", pc_o, 32'h1c00_0020);
    cycle();

    // redirect into the middle of a block
    drive(1, 1, 32'h1c00_0108, 0, '0, '0, 0);
    cycle();
    drive(1, 0, '0, 0, '0, '0, 0);
    #1;
    chk("redir_pc", pc_o, 32'h1c00_0108);
    chk("redir_valid", 32'(valid_o), 32'hc);
    cycle();
    chk("redir_seq", pc_o, 32'h1c00_0110);

    // train a taken branch in slot 1, update and redirect together
    drive(1, 1, 32'h1c00_0020, 1, 32'h1c00_0024, 32'h1c00_0400, 1);
    cycle();
    drive(1, 0, '0, 0, '0, '0, 0);
    #1;
    chk("tk_pred", 32'(pred_taken_o), 32'h1);
    chk("tk_slot", 32'(pred_slot_o), 32'h1);
    chk("tk_valid", 32'(valid_o), 32'h3);
    chk("tk_npc", npc_o, 32'h1c00_0400);
    cycle();

    // two not-taken updates: 10 -> 01 -> 00, then one taken: 00 -> 01, still off
    drive(1, 1, 32'h1c00_0020, 1, 32'h1c00_0024, '0, 0);
    cycle();
    drive(1, 0, '0, 0, '0, '0, 0);
    #1;
    chk("nt1_pred", 32'(pred_taken_o), 32'h0);
    chk("nt1_valid", 32'(valid_o), 32'hf);
    chk("nt1_npc", npc_o, 32'h1c00_0030);
    drive(1, 1, 32'h1c00_0020, 1, 32'h1c00_0024, '0, 0);
    cycle();
    drive(1, 1, 32'h1c00_0020, 1, 32'h1c00_0024, 32'h1c00_0400, 1);
    cycle();
    drive(1, 0, '0, 0, '0, '0, 0);
    #1;
    chk("floor_pred", 32'(pred_taken_o), 32'h0);
    cycle();

    // stall: hold pc, then redirect while stalled
    drive(0, 0, '0, 0, '0, '0, 0);
    repeat (3) cycle();
    drive(0, 1, 32'h1c00_0203, 0, '0, '0, 0);
    cycle();
    chk("stall_redir", pc_o, 32'h1c00_0200);

    // retrain, then reset mid-run with an update pending across the reset edge
    drive(1, 1, 32'h1c00_0040, 1, 32'h1c00_0040, 32'h1c00_0800, 1);
    cycle();
    drive(1, 0, '0, 1, 32'h1c00_0048, 32'h1c00_0900, 1);
    #2;
    a_rst = 1'b1;
    #1;
    chk("arst_pc", pc_o, RST_PC);
    chk("arst_valid", 32'(valid_o), 32'h0);
    chk("arst_pred", 32'(pred_taken_o), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    drive(1, 1, 32'h1c00_0040, 0, '0, '0, 0);
    @(posedge clk); #1;
    m_pc = 32'h1c00_0040;
    drive(1, 0, '0, 0, '0, '0, 0);
    #1;
    chk("post_rst_pred", 32'(pred_taken_o), 32'h0);
    cycle();

    // wrap at the top of the address space
    drive(1, 1, 32'hffff_fff0, 0, '0, '0, 0);
    cycle();
    drive(1, 0, '0, 0, '0, '0, 0);
    cycle();
    chk("wrap_pc", pc_o, 32'h0);

    // randomized traffic concentrated in a small window to create hits
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rpc, upc, utgt;
      rpc  = ($urandom_range(0, 9) == 0) ? $urandom : 32'h1c00_0000 + 32'($urandom_range(0, 255));
      upc  = ($urandom_range(0, 1) == 0) ? ((m_pc & ~32'hF) + 32'(4 * $urandom_range(0, 3)))
                                         : 32'h1c00_0000 + 32'(4 * $urandom_range(0, 63));
      utgt = 32'h1c00_0000 + 32'(4 * $urandom_range(0, 63));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rpc,
            $urandom_range(0, 1) == 1, upc, utgt, $urandom_range(0, 2) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
